// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch (I) and load/store (D)
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   i_req/i_addr -> i_done/i_rdata fetch requester: level request, one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata      data requester: level request held until d_done
//   d_done/d_rdata                 data completion pulse and load data
//   mem_req/mem_we/mem_addr/...    single-port memory handshake, completes on mem_ready
//   err                            qualifies a done pulse: access aborted by timeout
//   busy                           arbiter is not idle
module riscv_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t                state_q, state_d;
    // Doubles as "port currently granted" while a transaction is in flight
    // and as the round-robin memory once back in IDLE: 1 = D, 0 = I.
    logic                  last_d_q, last_d_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        // Done and err are pulses that only live in RESP.
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // I wins when alone, or when both request and D went last.
                if (i_req && (!d_req || last_d_q)) begin
                    last_d_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    cnt_d       = 8'd0;
                    state_d     = ACCESS;
                end else if (d_req) begin
                    last_d_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = 8'd0;
                    state_d     = ACCESS;
                end
            end

            ACCESS: begin
                // mem_ready is checked first so it wins on the timeout cycle.
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        if (last_d_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    i_done_d  = !last_d_q;
                    d_done_d  = last_d_q;
                    state_d   = RESP;
                end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                    if (!mem_we_q) begin
                        if (last_d_q) begin
                            d_rdata_d = '0;
                        end else begin
                            i_rdata_d = '0;
                        end
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    i_done_d  = !last_d_q;
                    d_done_d  = last_d_q;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign i_done    = i_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam logic [31:0] I_BASE = 32'h0040_0000;
    localparam logic [31:0] D_BASE = 32'h1001_0000;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    riscv_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit reached, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          rdy_cyc;    // mem_req cycle (1-based) in which mem_ready is high, 0 = never
        logic [31:0] rdata;
        int          exp_port;   // 0 = I, 1 = D
        int          exp_cycles; // number of cycles mem_req stays high
        logic        exp_err;
        logic [31:0] exp_rdata;  // expected rdata of the granted port after done
    } vec_t;

    vec_t vecs [11];

    // Called at a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic run_vec(input vec_t v, input string tag);
        int          cyc;
        int          len;
        int          stray;
        logic [31:0] exp_addr;
        i_req     = v.i_req;
        i_addr    = v.i_addr;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        mem_ready = 1'b0;
        exp_addr  = (v.exp_port == 0) ? v.i_addr : v.d_addr;
        cyc       = 0;
        stray     = 0;
        while (!mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (!mem_req) begin
            chk({tag, "_grant_timeout"}, 32'(mem_req), 32'd1);
            return;
        end
        chk({tag, "_mem_addr"}, mem_addr, exp_addr);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'((v.exp_port == 1) && v.d_we));
        if (v.exp_port == 1 && v.d_we) chk({tag, "_mem_wdata"}, mem_wdata, v.d_wdata);
        len = 0;
        while (mem_req && len < 50) begin
            len++;
            if (i_done || d_done) stray++;
            mem_ready = (len == v.rdy_cyc);
            mem_rdata = mem_ready ? v.rdata : 32'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        chk({tag, "_req_cycles"}, 32'(len), 32'(v.exp_cycles));
        chk({tag, "_stray_done"}, 32'(stray), 32'd0);
        chk({tag, "_i_done"}, 32'(i_done), 32'(v.exp_port == 0));
        chk({tag, "_d_done"}, 32'(d_done), 32'(v.exp_port == 1));
        chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
        chk({tag, "_busy_resp"}, 32'(busy), 32'd1);
        if (v.exp_port == 0) chk({tag, "_i_rdata"}, i_rdata, v.exp_rdata);
        else                 chk({tag, "_d_rdata"}, d_rdata, v.exp_rdata);
        if (v.exp_port == 0) i_req = 1'b0;
        else                 d_req = 1'b0;
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'({i_done, d_done}), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    // Random phase: bench-side requesters, memory and transaction-level model.
    logic [31:0] mem_m [16];
    logic [31:0] i_rd_m, d_rd_m, cur_rdata, cur_wdata;
    logic        i_pend, d_pend, last_was_d, mem_prev, ir_e, dr_e, cur_we, cur_err;
    int          cur_port, cur_w, cur_cnt, cur_idx, i_idx, d_idx, n_txn;

    initial begin
        rst       = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        //                i_req i_addr        d_req we d_addr        d_wdata       rdy rdata         port cyc err exp_rdata
        vecs[0]  = '{1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0,        32'h0,        2, 32'h0050_0093, 0, 2, 1'b0, 32'h0050_0093};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 1, 32'h5555_5555, 1, 1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h1001_0004, 32'h0,        1, 32'h1111_1111, 0, 1, 1'b0, 32'h1111_1111};
        vecs[3]  = '{1'b1, 32'h0040_0008, 1'b1, 1'b0, 32'h1001_0004, 32'h0,        1, 32'h2222_2222, 1, 1, 1'b0, 32'h2222_2222};
        vecs[4]  = '{1'b1, 32'h0040_0008, 1'b1, 1'b0, 32'h1001_0008, 32'h0,        1, 32'h3333_3333, 0, 1, 1'b0, 32'h3333_3333};
        vecs[5]  = '{1'b1, 32'h0040_000C, 1'b1, 1'b0, 32'h1001_0008, 32'h0,        1, 32'h4444_4444, 1, 1, 1'b0, 32'h4444_4444};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h1001_0020, 32'h0,        0, 32'h7777_7777, 1, 4, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h1001_0024, 32'h0,        1, 32'h5A5A_5A5A, 1, 1, 1'b0, 32'h5A5A_5A5A};
        vecs[8]  = '{1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0,        32'h0,        4, 32'h1234_5678, 0, 4, 1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b1, 32'h0040_0104, 1'b0, 1'b0, 32'h0,        32'h0,        5, 32'h9999_9999, 0, 4, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h1001_0030, 32'hCAFE_F00D, 0, 32'h6666_6666, 1, 4, 1'b1, 32'h5A5A_5A5A};

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_i_done", 32'(i_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset in the middle of a D load; a waiting fetch must win afterwards.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0040; i_req = 1'b0;
        for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
        chk("midrst_grant_d", mem_addr, 32'h1001_0040);
        i_req  = 1'b1;
        i_addr = 32'h0040_0040;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_req_async", 32'(mem_req), 32'd0);
        chk("midrst_busy_async", 32'(busy), 32'd0);
        chk("midrst_dones_async", 32'({i_done, d_done}), 32'd0);
        @(negedge clk);
        chk("midrst_mem_req_held", 32'(mem_req), 32'd0);
        chk("midrst_dones_held", 32'({i_done, d_done}), 32'd0);
        rst = 1'b1;
        run_vec('{1'b1, 32'h0040_0040, 1'b1, 1'b0, 32'h1001_0040, 32'h0, 1, 32'hCAFE_0001, 0, 1, 1'b0, 32'hCAFE_0001}, "postrst_i");
        run_vec('{1'b0, 32'h0040_0040, 1'b1, 1'b0, 32'h1001_0040, 32'h0, 2, 32'h0BAD_F00D, 1, 2, 1'b0, 32'h0BAD_F00D}, "postrst_d");

        // Randomized traffic against the transaction-level model.
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) mem_m[k] = 32'($urandom);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        i_rd_m = '0; d_rd_m = '0; last_was_d = 1'b1; mem_prev = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0; n_txn = 0;
        cur_port = 0; cur_w = 0; cur_cnt = 0; cur_idx = 0; cur_we = 1'b0; cur_err = 1'b0;
        cur_rdata = '0; cur_wdata = '0; i_idx = 0; d_idx = 0;

        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            ir_e = i_req;
            dr_e = d_req;

            if (mem_req && !mem_prev) begin
                if (ir_e && dr_e) cur_port = last_was_d ? 0 : 1;
                else if (ir_e)    cur_port = 0;
                else if (dr_e)    cur_port = 1;
                else begin
                    chk("rnd_grant_without_req", 32'd1, 32'd0);
                    cur_port = 0;
                end
                last_was_d = (cur_port == 1);
                cur_we     = (cur_port == 1) ? d_we : 1'b0;
                cur_idx    = (cur_port == 1) ? d_idx : i_idx;
                cur_wdata  = d_wdata;
                chk("rnd_grant_addr", mem_addr, (cur_port == 1) ? d_addr : i_addr);
                chk("rnd_grant_we", 32'(mem_we), 32'(cur_we));
                if (cur_we) chk("rnd_grant_wdata", mem_wdata, cur_wdata);
                cur_w     = $urandom_range(0, 5);
                cur_err   = (cur_w >= TMO);
                cur_rdata = mem_m[cur_idx];
                cur_cnt   = 0;
            end

            if (mem_prev && !mem_req) begin
                chk("rnd_req_cycles", 32'(cur_cnt), 32'(cur_err ? TMO : cur_w + 1));
                chk("rnd_i_done", 32'(i_done), 32'(cur_port == 0));
                chk("rnd_d_done", 32'(d_done), 32'(cur_port == 1));
                chk("rnd_err", 32'(err), 32'(cur_err));
                if (!cur_we) begin
                    if (cur_port == 0) i_rd_m = cur_err ? 32'd0 : cur_rdata;
                    else               d_rd_m = cur_err ? 32'd0 : cur_rdata;
                end
                chk("rnd_i_rdata", i_rdata, i_rd_m);
                chk("rnd_d_rdata", d_rdata, d_rd_m);
                n_txn++;
                if (cur_port == 0) begin i_pend = 1'b0; i_req = 1'b0; end
                else               begin d_pend = 1'b0; d_req = 1'b0; end
            end else if (i_done || d_done) begin
                chk("rnd_stray_done", 32'({i_done, d_done}), 32'd0);
            end

            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                i_idx  = $urandom_range(0, 15);
                i_addr = I_BASE + 32'(i_idx) * 32'd4;
                i_req  = 1'b1;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend  = 1'b1;
                d_idx   = $urandom_range(0, 15);
                d_addr  = D_BASE + 32'(d_idx) * 32'd4;
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = 32'($urandom);
                d_req   = 1'b1;
            end

            mem_ready = 1'b0;
            if (mem_req) begin
                cur_cnt++;
                if (cur_cnt == cur_w + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_m[cur_idx];
                    if (cur_we) mem_m[cur_idx] = cur_wdata;
                end else begin
                    mem_rdata = 32'($urandom);
                end
            end
            mem_prev = mem_req;
        end
        chk("rnd_progress", 32'(n_txn >= 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
